alu_shift_seq: RTL

ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

---
 rtl/alu_shift_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_shift_seq.sv
// rtl/alu_shift_seq.sv - multi-cycle shifter (SLL/SRL/SRA, ROR when ALU_SHIFT_SEQ_ROR_EN is defined)
// Shifts at most STEP bits per cycle; result is held in DONE until the consumer takes it.
module alu_shift_seq #(
    parameter int DATA_W  = 32,
    parameter int STEP    = 4,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [1:0]          i_op,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [SHAMT_W-1:0]  i_shamt,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_W-1:0]   o_result,
    output logic                o_busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W + 1)'(STEP);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          op_q, op_d;
    logic [SHAMT_W-1:0]  rem_q, rem_d;
    logic                sign_q, sign_d;

    logic [SHAMT_W-1:0]  amt;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   shifted;

    // STEP may equal DATA_W, which does not fit SHAMT_W; remaining never reaches it then.
    always_comb begin
        if ({1'b0, rem_q} >= STEP_C) begin
            amt = STEP_C[SHAMT_W-1:0];
        end else begin
            amt = rem_q;
        end
    end

    // Right shifts pull bits from 'hi': zeros, the sign, or the operand itself for rotate.
    always_comb begin
        hi = '0;
        case (op_q)
            2'b10:   hi = {DATA_W{sign_q}};
`ifdef ALU_SHIFT_SEQ_ROR_EN
            2'b11:   hi = data_q;
`endif
            default: hi = '0;
        endcase
        if (op_q == 2'b00) begin
            shifted = data_q << amt;
        end else begin
            shifted = (data_q >> amt) | (hi << (DATA_W - int'(amt)));
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        rem_d   = rem_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    data_d  = i_data;
                    op_d    = i_op;
                    rem_d   = i_shamt;
                    sign_d  = i_data[DATA_W-1];
                    state_d = (i_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = shifted;
                rem_d  = rem_q - amt;
                if (rem_q == amt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            sign_q  <= sign_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_busy   = (state_q != IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_result = (state_q == DONE) ? data_q : '0;

endmodule
